// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive-side controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package uart_rx_ctrl_pkg;

    // Parity type encodings as seen by UART_Rx.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // UART_Rx configuration word.
    typedef struct packed {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
    } rx_cfg_t;

    // Settings loaded at reset: 8x oversampling, no parity.
    localparam rx_cfg_t CFG_RST = '{prescale: 6'd8, par_en: 1'b0, par_typ: EVEN};

    // Config state machine states.
    typedef enum logic [1:0] {
        CFG_RUN   = 2'd0,
        CFG_PEND  = 2'd1,
        CFG_APPLY = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO holding good received characters; head is read straight from storage.
// Latency: a push into an empty FIFO is visible at the head on the next cycle.
// Backpressure: full/empty exported; caller must not push when full unless popping in the same cycle.
//
// Ports: CLK/RST (sync active-high), i_push/i_push_dat write side,
//        i_pop read side, o_head_dat current head, o_full/o_empty status.
module uart_rx_ctrl_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_dat,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_head_dat = r_mem[w_rd_idx];

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // When full with a simultaneous pop, the write lands on the slot
            // being popped; the old value is still presented this cycle.
            if (i_push) begin
                r_mem[w_wr_idx] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + (AW+1)'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART_Rx control: owns Prescale/PAR_EN/PAR_TYP, buffers good frames, counts errors, flags overrun.
// Latency: good frame to out_valid 1 cycle; config applied IDLE_CYCLES+1 cycles after cfg_wr on an idle line.
// Backpressure: out_valid/out_ready on the output; frames arriving to a full FIFO are dropped and set overrun.
//
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   cfg_wr, cfg_prescale/par_en/par_typ, cfg_busy   config request and pending flag
//   rx_line                         raw serial line, watched for idle
//   Prescale, PAR_EN, PAR_TYP, rx_rst_n             drive UART_Rx
//   rx_p_data, rx_data_valid, rx_parity_error, rx_stop_error   from UART_Rx
//   out_data, out_valid, out_ready  consumer handshake
//   clr_status, overrun, par_err_cnt, stop_err_cnt  status
// Build option: define UART_RX_CTRL_ERR_CNT_EN to build the error counters;
// otherwise par_err_cnt/stop_err_cnt are tied to zero.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int IDLE_CYCLES   = 160,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cfg_wr,
    input  logic [5:0]               cfg_prescale,
    input  logic                     cfg_par_en,
    input  logic                     cfg_par_typ,
    output logic                     cfg_busy,
    input  logic                     rx_line,
    output logic [5:0]               Prescale,
    output logic                     PAR_EN,
    output logic                     PAR_TYP,
    output logic                     rx_rst_n,
    input  logic [DATA_WIDTH-1:0]    rx_p_data,
    input  logic                     rx_data_valid,
    input  logic                     rx_parity_error,
    input  logic                     rx_stop_error,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clr_status,
    output logic                     overrun,
    output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] stop_err_cnt
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

    // Plain-vector state encoding, values taken from the shared enum.
    localparam logic [1:0] ST_RUN   = CFG_RUN;
    localparam logic [1:0] ST_PEND  = CFG_PEND;
    localparam logic [1:0] ST_APPLY = CFG_APPLY;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Configuration
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [IDLE_W-1:0] r_idle_cnt;
    rx_cfg_t           r_cfg;
    rx_cfg_t           r_cfg_pend;
    rx_cfg_t           w_cfg_in;

    assign w_cfg_in = '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_RUN;
            r_idle_cnt <= '0;
            r_cfg      <= CFG_RST;
            r_cfg_pend <= CFG_RST;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (cfg_wr) begin
                        r_cfg_pend <= w_cfg_in;
                        r_idle_cnt <= '0;
                        r_state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // A rewrite while pending keeps the idle run already seen.
                    if (cfg_wr) begin
                        r_cfg_pend <= w_cfg_in;
                    end
                    if (rx_line) begin
                        if (r_idle_cnt == IDLE_LAST) begin
                            r_idle_cnt <= '0;
                            r_state    <= ST_APPLY;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end else begin
                        r_idle_cnt <= '0;
                    end
                end
                ST_APPLY: begin
                    // The apply still uses the old pending word; a write in
                    // this cycle becomes the next pending request.
                    r_cfg      <= r_cfg_pend;
                    r_idle_cnt <= '0;
                    if (cfg_wr) begin
                        r_cfg_pend <= w_cfg_in;
                        r_state    <= ST_PEND;
                    end else begin
                        r_state    <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign Prescale = r_cfg.prescale;
    assign PAR_EN   = r_cfg.par_en;
    assign PAR_TYP  = r_cfg.par_typ;
    // Datapath is held in reset for the single apply cycle.
    assign rx_rst_n = (r_state != ST_APPLY);
    assign cfg_busy = (r_state != ST_RUN);

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_full;
    logic w_empty;

    assign w_push_req = rx_data_valid & ~rx_parity_error & ~rx_stop_error;
    assign w_pop      = ~w_empty & out_ready;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    uart_rx_ctrl_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .i_push     (w_push),
        .i_push_dat (rx_p_data),
        .i_pop      (w_pop),
        .o_head_dat (out_data),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign out_valid = ~w_empty;

    logic r_overrun;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overrun <= 1'b0;
        end else if (clr_status) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;

    // ------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic                     r_par_err_q;
    logic                     r_stop_err_q;
    logic [ERR_CNT_WIDTH-1:0] r_par_cnt;
    logic [ERR_CNT_WIDTH-1:0] r_stop_cnt;
    logic                     w_par_rise;
    logic                     w_stop_rise;

    // Count rising edges so a multi-cycle error flag counts once.
    assign w_par_rise  = rx_parity_error & ~r_par_err_q;
    assign w_stop_rise = rx_stop_error & ~r_stop_err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_par_err_q  <= 1'b0;
            r_stop_err_q <= 1'b0;
            r_par_cnt    <= '0;
            r_stop_cnt   <= '0;
        end else begin
            r_par_err_q  <= rx_parity_error;
            r_stop_err_q <= rx_stop_error;
            if (clr_status) begin
                r_par_cnt  <= '0;
                r_stop_cnt <= '0;
            end else begin
                if (w_par_rise && (r_par_cnt != '1)) begin
                    r_par_cnt <= r_par_cnt + ERR_CNT_WIDTH'(1);
                end
                if (w_stop_rise && (r_stop_cnt != '1)) begin
                    r_stop_cnt <= r_stop_cnt + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

    assign par_err_cnt  = r_par_cnt;
    assign stop_err_cnt = r_stop_cnt;
`else
    assign par_err_cnt  = '0;
    assign stop_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: out_ready driven both steadily and in random bursts.
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int IDLE  = 160;
    localparam int EW    = 8;
    localparam int CMAX  = (1 << EW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [5:0]    cfg_prescale = 6'd8;
    logic          cfg_par_en = 1'b0;
    logic          cfg_par_typ = 1'b0;
    logic          cfg_busy;
    logic          rx_line = 1'b1;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          rx_rst_n;
    logic [DW-1:0] rx_p_data = '0;
    logic          rx_data_valid = 1'b0;
    logic          rx_parity_error = 1'b0;
    logic          rx_stop_error = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          clr_status = 1'b0;
    logic          overrun;
    logic [EW-1:0] par_err_cnt;
    logic [EW-1:0] stop_err_cnt;

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .IDLE_CYCLES   (IDLE),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .cfg_wr          (cfg_wr),
        .cfg_prescale    (cfg_prescale),
        .cfg_par_en      (cfg_par_en),
        .cfg_par_typ     (cfg_par_typ),
        .cfg_busy        (cfg_busy),
        .rx_line         (rx_line),
        .Prescale        (Prescale),
        .PAR_EN          (PAR_EN),
        .PAR_TYP         (PAR_TYP),
        .rx_rst_n        (rx_rst_n),
        .rx_p_data       (rx_p_data),
        .rx_data_valid   (rx_data_valid),
        .rx_parity_error (rx_parity_error),
        .rx_stop_error   (rx_stop_error),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .clr_status      (clr_status),
        .overrun         (overrun),
        .par_err_cnt     (par_err_cnt),
        .stop_err_cnt    (stop_err_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: FIFO as a queue, config as "pending until IDLE
    // consecutive idle samples, then one apply cycle".
    // ------------------------------------------------------------------
    logic [DW-1:0] mq[$];
    bit            m_ovr;
    int            m_pcnt, m_scnt;
    bit            m_pe_q, m_se_q;
    logic [5:0]    m_pres, p_pres;
    bit            m_pen, m_ptyp, p_pen, p_ptyp;
    bit            m_wait, m_apply;
    int            m_run;
    bit            t_wait, t_app, t_pop, t_push, t_full;

    always @(posedge CLK) begin
        if (RST) begin
            mq.delete();
            m_ovr = 0; m_pcnt = 0; m_scnt = 0; m_pe_q = 0; m_se_q = 0;
            m_pres = 6'd8; m_pen = 0; m_ptyp = 0;
            p_pres = 6'd8; p_pen = 0; p_ptyp = 0;
            m_wait = 0; m_apply = 0; m_run = 0;
        end else begin
            t_wait = m_wait;
            t_app  = m_apply;
            m_apply = 0;
            if (t_app) begin
                m_pres = p_pres; m_pen = p_pen; m_ptyp = p_ptyp;
            end
            if (t_wait) begin
                if (rx_line) begin
                    m_run++;
                    if (m_run == IDLE) begin
                        m_wait = 0; m_apply = 1;
                    end
                end else begin
                    m_run = 0;
                end
            end
            if (cfg_wr) begin
                p_pres = cfg_prescale; p_pen = cfg_par_en; p_ptyp = cfg_par_typ;
                if (!t_wait) begin
                    m_wait = 1; m_apply = 0; m_run = 0;
                end
            end

            t_pop  = (mq.size() > 0) && out_ready;
            t_push = rx_data_valid && !rx_parity_error && !rx_stop_error;
            t_full = (mq.size() == DEPTH);
            if (t_pop) void'(mq.pop_front());
            if (t_push) begin
                if (t_full && !t_pop) m_ovr = 1;
                else mq.push_back(rx_p_data);
            end

            if (rx_parity_error && !m_pe_q && m_pcnt < CMAX) m_pcnt++;
            if (rx_stop_error && !m_se_q && m_scnt < CMAX) m_scnt++;
            m_pe_q = rx_parity_error;
            m_se_q = rx_stop_error;
            if (clr_status) begin
                m_ovr = 0; m_pcnt = 0; m_scnt = 0;
            end
        end
    end

    function automatic int exp_cnt(input int v);
`ifdef UART_RX_CTRL_ERR_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("par_err_cnt", 32'(par_err_cnt), exp_cnt(m_pcnt));
            chk("stop_err_cnt", 32'(stop_err_cnt), exp_cnt(m_scnt));
            chk("cfg", 32'({Prescale, PAR_EN, PAR_TYP}), 32'({m_pres, m_pen, m_ptyp}));
            chk("rx_rst_n", 32'(rx_rst_n), 32'(!m_apply));
            chk("cfg_busy", 32'(cfg_busy), 32'(m_wait || m_apply));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame(input logic [DW-1:0] d, input bit pe, input bit se);
        rx_data_valid = 1'b1; rx_p_data = d; rx_parity_error = pe; rx_stop_error = se;
        tick();
        rx_data_valid = 1'b0; rx_parity_error = 1'b0; rx_stop_error = 1'b0;
    endtask

    task automatic write_cfg(input logic [5:0] p, input bit en, input bit typ);
        cfg_wr = 1'b1; cfg_prescale = p; cfg_par_en = en; cfg_par_typ = typ;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
    endtask

    logic [DW-1:0] ovf [9];

    initial begin
        tick(3);
        RST = 1'b0;
        chk_en = 1'b1;

        // Reset values.
        chk("rst_prescale", 32'(Prescale), 32'd8);
        chk("rst_par_en", 32'(PAR_EN), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        chk("rst_rx_rst_n", 32'(rx_rst_n), 32'd1);

        // Config applied on an idle line: Prescale changes IDLE+1 edges after the cfg_wr edge.
        write_cfg(6'd16, 1'b1, 1'b1);
        chk("apply_busy0", 32'(cfg_busy), 32'd1);
        tick(IDLE - 1);
        chk("apply_pre_rstn", 32'(rx_rst_n), 32'd1);
        chk("apply_pre_pres", 32'(Prescale), 32'd8);
        tick();
        chk("apply_rstn_low", 32'(rx_rst_n), 32'd0);
        chk("apply_hold_pres", 32'(Prescale), 32'd8);
        tick();
        chk("apply_pres16", 32'(Prescale), 32'd16);
        chk("apply_paren", 32'(PAR_EN), 32'd1);
        chk("apply_partyp", 32'(PAR_TYP), 32'd1);
        chk("apply_rstn_high", 32'(rx_rst_n), 32'd1);
        chk("apply_busy_done", 32'(cfg_busy), 32'd0);

        // Line activity at idle count 100 restarts the idle run.
        write_cfg(6'd32, 1'b0, 1'b0);
        tick(100);
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        tick(IDLE - 1);
        chk("defer_busy", 32'(cfg_busy), 32'd1);
        chk("defer_pres_old", 32'(Prescale), 32'd16);
        tick();
        chk("defer_rstn_low", 32'(rx_rst_n), 32'd0);
        tick();
        chk("defer_pres32", 32'(Prescale), 32'd32);
        chk("defer_busy_done", 32'(cfg_busy), 32'd0);

        // Two good frames streaming out with the consumer ready.
        out_ready = 1'b1;
        frame(8'hB2, 0, 0);
        chk("stream_first", 32'(out_data), 32'hB2);
        chk("stream_valid", 32'(out_valid), 32'd1);
        rx_data_valid = 1'b1; rx_p_data = 8'hA4;
        tick();
        rx_data_valid = 1'b0;
        chk("stream_second", 32'(out_data), 32'hA4);
        tick();
        chk("stream_empty", 32'(out_valid), 32'd0);
        chk("stream_ovr", 32'(overrun), 32'd0);

        // Overflow: nine frames into a stalled FIFO, the ninth is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ovf[i] = 8'(i * 37 + 5);
            frame(ovf[i], 0, 0);
        end
        chk("ovf_overrun", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_drain", 32'(out_data), 32'(ovf[i]));
            tick();
        end
        chk("ovf_drained", 32'(out_valid), 32'd0);
        pulse_clr();
        chk("ovf_clr", 32'(overrun), 32'd0);

        // Error counting: a 3-cycle parity flag counts once.
        frame(8'h11, 1, 0);
        tick();
        frame(8'h22, 1, 0);
        tick();
        rx_data_valid = 1'b1; rx_parity_error = 1'b1;
        tick(3);
        rx_data_valid = 1'b0; rx_parity_error = 1'b0;
        tick();
        frame(8'h33, 0, 1);
        tick();
        chk("err_par3", 32'(par_err_cnt), 32'(exp_cnt(3)));
        chk("err_stop1", 32'(stop_err_cnt), 32'(exp_cnt(1)));
        chk("err_fifo_empty", 32'(out_valid), 32'd0);
        pulse_clr();
        chk("err_clr_par", 32'(par_err_cnt), 32'd0);
        chk("err_clr_stop", 32'(stop_err_cnt), 32'd0);

        // Saturation at all-ones.
        for (int i = 0; i < CMAX + 5; i++) begin
            rx_parity_error = 1'b1;
            tick();
            rx_parity_error = 1'b0;
            tick();
        end
        chk("err_sat", 32'(par_err_cnt), 32'(exp_cnt(CMAX)));
        pulse_clr();

        // Randomized traffic, config writes and line activity.
        for (int c = 0; c < 4000; c++) begin
            rx_line         = ($urandom_range(399) != 0);
            cfg_wr          = ($urandom_range(299) == 0) || (m_apply && ($urandom_range(1) != 0));
            case ($urandom_range(2))
                0:       cfg_prescale = 6'd8;
                1:       cfg_prescale = 6'd16;
                default: cfg_prescale = 6'd32;
            endcase
            cfg_par_en      = ($urandom_range(1) != 0);
            cfg_par_typ     = ($urandom_range(1) != 0);
            rx_data_valid   = !m_apply && ($urandom_range(2) == 0);
            rx_p_data       = 8'($urandom);
            rx_parity_error = ($urandom_range(7) == 0);
            rx_stop_error   = ($urandom_range(7) == 0);
            out_ready       = ((c % 200) < 100) ? ($urandom_range(3) == 0) : ($urandom_range(1) != 0);
            clr_status      = ($urandom_range(99) == 0);
            tick();
        end
        cfg_wr = 1'b0; rx_data_valid = 1'b0; rx_parity_error = 1'b0;
        rx_stop_error = 1'b0; clr_status = 1'b0; rx_line = 1'b1;
        tick(5);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
